aes_inv_key_schedule: RTL and testbench

Produces AES-128 round keys in reverse order (round 10 down to round 0) for the decryption datapath. It is the counterpart of the forward per-round key expansion used by the encryption core. On `start` it expands the cipher key forward once to reach the round-10 key. It then walks backward one round key per `next` request, using the inverse key-expansion recurrence and the shared synchronous S-box.

---
 rtl/aes_pkg.sv | 38 +++
 rtl/aes_subword_sync.sv | 16 +
 rtl/sbox_sync.sv | 31 +++
 rtl/aes_inv_key_schedule.sv | 133 +++++++++++++
 tb/tb_aes_inv_key_schedule.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, key-schedule state encoding and word helpers.
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;
    localparam int         NK = 4;

    typedef enum logic [2:0] {
        IDLE,
        FWD_SUB,
        FWD_UPD,
        READY,
        INV_SUB,
        INV_UPD
    } state_t;

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] b;
        case (r)
            4'd1:    b = 8'h01;
            4'd2:    b = 8'h02;
            4'd3:    b = 8'h04;
            4'd4:    b = 8'h08;
            4'd5:    b = 8'h10;
            4'd6:    b = 8'h20;
            4'd7:    b = 8'h40;
            4'd8:    b = 8'h80;
            4'd9:    b = 8'h1b;
            4'd10:   b = 8'h36;
            default: b = 8'h00;
        endcase
        return {b, 24'h000000};
    endfunction

endpackage

// File: rtl/aes_subword_sync.sv
// SubWord on one 32-bit word through four synchronous S-box lookups (one cycle latency).
module aes_subword_sync (
    input  logic        clk,
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    for (genvar i = 0; i < 4; i++) begin : g_byte
        sbox_sync u_sbox (
            .clk  (clk),
            .addr (word_in[8*i +: 8]),
            .data (word_out[8*i +: 8])
        );
    end

endmodule

// File: rtl/sbox_sync.sv
// AES forward S-box with a registered output: address in cycle N, data in cycle N+1.
module sbox_sync (
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] data
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    always_ff @(posedge clk) begin
        data <= SBOX[addr];
    end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 round keys delivered from round 10 down to round 0 for decryption.
// Optional AES_INV_KS_CACHE_EN stores all 11 round keys so inverse steps skip the S-box.
//
// state   | meaning
// IDLE    | no key loaded, outputs parked
// FWD_SUB | forward step: RotWord(k3) presented to the S-box
// FWD_UPD | forward step: next round key registered
// READY   | round_key/round valid, waiting for next
// INV_SUB | inverse step: p1..p3 registered, RotWord(p3) presented to the S-box
// INV_UPD | inverse step: p0 (or cached key) registered, round decremented
module aes_inv_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         next,
    output logic [127:0] round_key,
    output logic [3:0]   round,
    output logic         valid,
    output logic         busy,
    output logic         last
);

    state_t      state;
    logic [31:0] kw [NK];
    logic [31:0] sbox_addr;
    logic [31:0] sbox_data;
    logic [31:0] t_word;
    logic [31:0] n0, n1, n2, n3;
    logic [3:0]  round_inc;
    logic [3:0]  round_dec;

    always_comb begin
        for (int i = 0; i < NK; i++) begin
            kw[i] = round_key[127-32*i -: 32];
        end
    end

    assign round_inc = round + 4'd1;
    assign round_dec = round - 4'd1;

    // One S-box serves both directions; only INV_SUB needs the derived p3 word.
    assign sbox_addr = (state == INV_SUB) ? rot_word(kw[3] ^ kw[2]) : rot_word(kw[3]);

    aes_subword_sync u_subword (
        .clk      (clk),
        .word_in  (sbox_addr),
        .word_out (sbox_data)
    );

    assign t_word = sbox_data ^ rcon(round_inc);
    assign n0     = kw[0] ^ t_word;
    assign n1     = kw[1] ^ n0;
    assign n2     = kw[2] ^ n1;
    assign n3     = kw[3] ^ n2;

`ifdef AES_INV_KS_CACHE_EN
    logic [127:0] cache [0:10];

    always_ff @(posedge clk) begin
        if (start) begin
            cache[0] <= key_in;
        end else if (state == FWD_UPD) begin
            cache[round_inc] <= {n0, n1, n2, n3};
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            round_key <= '0;
            round     <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            last      <= 1'b0;
        end else if (start) begin
            state     <= FWD_SUB;
            round_key <= key_in;
            round     <= '0;
            valid     <= 1'b0;
            busy      <= 1'b1;
            last      <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                FWD_SUB: state <= FWD_UPD;
                FWD_UPD: begin
                    round_key <= {n0, n1, n2, n3};
                    round     <= round_inc;
                    if (round_inc == NR) begin
                        state <= READY;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= FWD_SUB;
                    end
                end
                READY: begin
                    if (next && valid && (round != 4'd0)) begin
                        busy <= 1'b1;
`ifdef AES_INV_KS_CACHE_EN
                        state <= INV_UPD;
`else
                        state <= INV_SUB;
                        valid <= 1'b0;
`endif
                    end
                end
                INV_SUB: begin
                    round_key <= {kw[0], kw[1] ^ kw[0], kw[2] ^ kw[1], kw[3] ^ kw[2]};
                    state     <= INV_UPD;
                end
                INV_UPD: begin
`ifdef AES_INV_KS_CACHE_EN
                    round_key <= cache[round_dec];
`else
                    round_key[127:96] <= kw[0] ^ sbox_data ^ rcon(round);
`endif
                    round <= round_dec;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    last  <= (round_dec == 4'd0);
                    state <= READY;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Scoreboard bench for aes_inv_key_schedule; reference key schedule built from a GF(2^8) S-box.
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [127:0] key_in;
    logic         next;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic         valid;
    logic         busy;
    logic         last;

    always #5 clk = ~clk;

    aes_inv_key_schedule dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .key_in    (key_in),
        .next      (next),
        .round_key (round_key),
        .round     (round),
        .valid     (valid),
        .busy      (busy),
        .last      (last)
    );

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    exp_t         exp_q [$];
    int           total = 0;
    int           bad   = 0;
    logic [7:0]   sb [256];
    logic [127:0] ref_keys [11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic compute_ref(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic push(input int r);
        exp_t e;
        e.rnd = 4'(r);
        e.key = ref_keys[r];
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            if (valid && !busy) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL wait_ready timeout valid=%0b busy=%0b", valid, busy);
        end
    endtask

    // mode 0: return after start is sampled, 1: wait for READY, 2: also check cycle timing
    task automatic do_start(input logic [127:0] k, input int mode);
        @(posedge clk);
        #1;
        start  = 1'b1;
        key_in = k;
        compute_ref(k);
        exp_q.delete();
        push(10);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (mode == 2) begin
            check("fwd_busy_set", busy, 1);
            check("fwd_valid_clr", valid, 0);
            repeat (19) @(posedge clk);
            #1;
            check("fwd_valid_e19", valid, 0);
            @(posedge clk);
            #1;
            check("fwd_valid_e20", valid, 1);
            check("fwd_round_e20", round, 10);
            check("fwd_busy_e20", busy, 0);
        end else if (mode == 1) begin
            wait_ready(40);
        end
    endtask

    task automatic do_next(input int cur, input bit lat);
        @(posedge clk);
        #1;
        next = 1'b1;
        if (cur > 0) push(cur - 1);
        @(posedge clk);
        #1;
        next = 1'b0;
        if (lat) begin
`ifdef AES_INV_KS_CACHE_EN
            check("step_hold_valid", valid, 1);
            check("step_hold_round", round, cur);
            @(posedge clk);
            #1;
            check("step_cache_round", round, cur - 1);
            check("step_cache_valid", valid, 1);
`else
            check("step_drop_valid", valid, 0);
            check("step_busy", busy, 1);
            @(posedge clk);
            #1;
            check("step_mid_valid", valid, 0);
            @(posedge clk);
            #1;
            check("step_round", round, cur - 1);
            check("step_valid", valid, 1);
`endif
        end else if (cur > 0) begin
            wait_ready(20);
        end else begin
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    // Monitor: a new output is a rising valid or a round change while valid.
    initial begin : monitor
        logic       pv;
        logic [3:0] pr;
        exp_t       e;
        pv = 1'b0;
        pr = 4'd0;
        forever begin
            @(negedge clk);
            if (valid && (!pv || round != pr)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output round=%0d key=%h", round, round_key);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_round", round, e.rnd);
                    check("mon_key", round_key, e.key);
                end
            end
            pv = valid;
            pr = round;
        end
    end

    initial begin : stim
        logic [127:0] k;
        bit           seen;
        reset_n = 1'b0;
        start   = 1'b0;
        next    = 1'b0;
        key_in  = '0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("rst_key", round_key, 0);
        check("rst_round", round, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_last", last, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Known-answer walk
        do_start(128'h2b7e151628aed2a6abf7158809cf4f3c, 2);
        check("kat_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        do_next(10, 1'b1);
        check("kat_r9", round_key, 128'hac7766f319fadc2128d12941575c006e);
        for (int r = 9; r >= 2; r--) do_next(r, 1'b0);
        check("kat_r1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
        do_next(1, 1'b1);
        check("kat_r0", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("kat_last", last, 1);
        do_next(0, 1'b0);
        check("r0_hold_key", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("r0_hold_round", round, 0);
        check("r0_hold_valid", valid, 1);
        check("r0_hold_last", last, 1);

        // next held high from round 10
        k = {$urandom, $urandom, $urandom, $urandom};
        do_start(k, 1);
        for (int r = 9; r >= 0; r--) push(r);
        @(posedge clk);
        #1;
        next = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (last) seen = 1'b1;
        end
        repeat (4) @(posedge clk);
        #1;
        next = 1'b0;
        check("held_last_seen", seen, 1);
        check("held_round", round, 0);
        check("held_key", round_key, ref_keys[0]);

        // start during the first cycle of an inverse step
        do_start({$urandom, $urandom, $urandom, $urandom}, 1);
        @(posedge clk);
        #1;
        next = 1'b1;
        @(posedge clk);
        #1;
        next   = 1'b0;
        start  = 1'b1;
        key_in = 128'h000102030405060708090a0b0c0d0e0f;
        compute_ref(key_in);
        exp_q.delete();
        push(10);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("abort_valid", valid, 0);
        repeat (19) @(posedge clk);
        #1;
        check("abort_valid_e19", valid, 0);
        @(posedge clk);
        #1;
        check("abort_valid_e20", valid, 1);
        check("abort_key", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // reset pulse in FWD_UPD
        @(posedge clk);
        #1;
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("rpulse_key", round_key, 0);
        check("rpulse_round", round, 0);
        check("rpulse_valid", valid, 0);
        check("rpulse_busy", busy, 0);
        check("rpulse_last", last, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            next = 1'b1;
            @(posedge clk);
            #1;
            next = 1'b0;
            check("idle_next_valid", valid, 0);
            check("idle_next_busy", busy, 0);
        end

        // randomized keys, aborted forward passes, random gaps between steps
        for (int n = 0; n < 4; n++) begin
            do_start({$urandom, $urandom, $urandom, $urandom}, 0);
            repeat ($urandom_range(0, 15)) @(posedge clk);
            do_start({$urandom, $urandom, $urandom, $urandom}, 1);
            for (int r = 10; r >= 1; r--) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                do_next(r, ($urandom_range(0, 3) == 0));
            end
            check("rand_last", last, 1);
            check("rand_key0", round_key, ref_keys[0]);
        end

        repeat (5) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
